mem_bank_pipe: RTL and testbench

- Byte-addressed, byte-strobed single-port memory bank with a valid/ready request channel and a valid/ready response channel.
- Read latency is configurable, and a credit-checked response FIFO absorbs backpressure.
- Every request, read or write, returns exactly one response, in order.
- Sits between an interconnect port and on-chip SRAM wherever stalls on the response side must not lose data.

---
 rtl/mem_bank_pipe_if.sv | 33 +++
 rtl/mem_bank_pipe.sv | 153 +++++++++++++++
 tb/tb_mem_bank_pipe.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bank_pipe_if.sv
// Request/response bundle between an interconnect port and one memory bank.
// Latency: none (wires only).
// Backpressure: req_ready_o stalls requests, rsp_ready_i stalls responses.
interface mem_bank_pipe_if #(
    parameter int AddrWidth = 8,
    parameter int DataSize  = 2
);
    localparam int DataBytes = 2 ** DataSize;
    localparam int DataWidth = 8 * DataBytes;

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_we_i;
    logic [AddrWidth-1:0] req_addr_i;
    logic [DataWidth-1:0] req_wdata_i;
    logic [DataBytes-1:0] req_wstrb_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic                 rsp_we_o;
    logic [DataWidth-1:0] rsp_rdata_o;

    // Requester side
    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_we_o, rsp_rdata_o
    );

    // Memory bank side
    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_we_o, rsp_rdata_o
    );
endinterface

// File: rtl/mem_bank_pipe.sv
// Byte-strobed single-port memory bank returning one in-order response per request.
// Latency: response enters the FIFO RdLatency-1 edges after accept, visible the cycle after.
// Backpressure: credit counter caps outstanding requests at RspDepth; req_ready_o is a flop.
module mem_bank_pipe #(
    parameter int AddrWidth = 8,
    parameter int DataSize  = 2,
    parameter int RdLatency = 1,
    parameter int RspDepth  = 4
) (
    input  logic            clk_i,
    input  logic            arst_ni,
    mem_bank_pipe_if.slave  bus
);
    localparam int DataBytes = 2 ** DataSize;
    localparam int DataWidth = 8 * DataBytes;
    localparam int MemBytes  = 2 ** AddrWidth;
    localparam int PtrW      = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int CntW      = $clog2(RspDepth + 1);

    typedef struct packed {
        logic                 we;
        logic [DataWidth-1:0] rdata;
    } rsp_t;

    logic [7:0]     mem_q [MemBytes];
    rsp_t           fifo_q [RspDepth];

    logic           acc;
    rsp_t           acc_rsp;
    logic           push;
    rsp_t           push_rsp;
    logic           pop;
    rsp_t           head;
    rsp_t           rsp_out;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CntW-1:0] out_cnt_q, out_cnt_d;
    logic            rdy_q, rdy_d;
    rsp_t            last_q, last_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RspDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Accept decision and byte-lane read lookup; lane addresses wrap at the top of memory
    always_comb begin
        acc     = bus.req_valid_i && rdy_q && arst_ni;
        acc_rsp = '0;
        acc_rsp.we = bus.req_we_i;
        if (!bus.req_we_i) begin
            for (int i = 0; i < DataBytes; i++) begin
                acc_rsp.rdata[8*i +: 8] = mem_q[bus.req_addr_i + AddrWidth'(i)];
            end
        end
    end

    // Storage array: committed on the accepting edge, never reset
    always_ff @(posedge clk_i) begin
        if (acc && bus.req_we_i) begin
            for (int i = 0; i < DataBytes; i++) begin
                if (bus.req_wstrb_i[i]) begin
                    mem_q[bus.req_addr_i + AddrWidth'(i)] <= bus.req_wdata_i[8*i +: 8];
                end
            end
        end
    end

    generate
        if (RdLatency == 1) begin : g_nopipe
            // Single-cycle latency pushes straight into the FIFO on the accepting edge
            always_comb begin
                push     = acc;
                push_rsp = acc_rsp;
            end
        end else begin : g_pipe
            localparam int Stages = RdLatency - 1;
            logic [Stages-1:0] vld_q, vld_d;
            rsp_t              dat_q [Stages];
            rsp_t              dat_d [Stages];

            // Shift accepted responses down the delay line
            always_comb begin
                vld_d[0] = acc;
                dat_d[0] = acc_rsp;
                for (int j = 1; j < Stages; j++) begin
                    vld_d[j] = vld_q[j-1];
                    dat_d[j] = dat_q[j-1];
                end
                push     = vld_q[Stages-1];
                push_rsp = dat_q[Stages-1];
            end

            // Delay-line registers; reset drops everything in flight
            always_ff @(posedge clk_i or negedge arst_ni) begin
                if (!arst_ni) begin
                    vld_q <= '0;
                    for (int j = 0; j < Stages; j++) dat_q[j] <= '0;
                end else begin
                    vld_q <= vld_d;
                    for (int j = 0; j < Stages; j++) dat_q[j] <= dat_d[j];
                end
            end
        end
    endgenerate

    // FIFO pointers, occupancy and credit bookkeeping; outstanding counts pipeline plus FIFO
    always_comb begin
        head       = fifo_q[rd_ptr_q];
        pop        = (fifo_cnt_q != '0) && bus.rsp_ready_i;
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);
        out_cnt_d  = out_cnt_q + CntW'(acc) - CntW'(pop);
        rdy_d      = (out_cnt_d < CntW'(RspDepth));
        last_d     = pop ? head : last_q;
        rsp_out    = (fifo_cnt_q != '0) ? head : last_q;
    end

    // Control state; a freed credit shows up on req_ready_o the cycle after the pop
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            out_cnt_q  <= '0;
            rdy_q      <= 1'b1;
            last_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            out_cnt_q  <= out_cnt_d;
            rdy_q      <= rdy_d;
            last_q     <= last_d;
        end
    end

    // Response FIFO payload; only slots behind a valid count are ever observed
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= push_rsp;
    end

    // Credits guarantee a free slot for every push
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!arst_ni)
        !(push && (fifo_cnt_q == CntW'(RspDepth))));

    assign bus.req_ready_o = rdy_q;
    assign bus.rsp_valid_o = (fifo_cnt_q != '0);
    assign bus.rsp_we_o    = rsp_out.we;
    assign bus.rsp_rdata_o = rsp_out.rdata;
endmodule

// File: tb/tb_mem_bank_pipe.sv
// Directed bench: RdLatency=1 bank for function/backpressure/reset, RdLatency=3 bank for streaming.
module tb_mem_bank_pipe;
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        arst_ni;
    logic        sel;
    logic        req_valid, req_we, rsp_ready;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rdy, vld, rsp_we;
    logic [31:0] rdata;

    mem_bank_pipe_if b1();
    mem_bank_pipe_if b3();

    assign b1.req_valid_i = req_valid && !sel;
    assign b1.req_we_i    = req_we;
    assign b1.req_addr_i  = req_addr;
    assign b1.req_wdata_i = req_wdata;
    assign b1.req_wstrb_i = req_wstrb;
    assign b1.rsp_ready_i = rsp_ready;
    assign b3.req_valid_i = req_valid && sel;
    assign b3.req_we_i    = req_we;
    assign b3.req_addr_i  = req_addr;
    assign b3.req_wdata_i = req_wdata;
    assign b3.req_wstrb_i = req_wstrb;
    assign b3.rsp_ready_i = rsp_ready;

    assign rdy    = sel ? b3.req_ready_o : b1.req_ready_o;
    assign vld    = sel ? b3.rsp_valid_o : b1.rsp_valid_o;
    assign rsp_we = sel ? b3.rsp_we_o    : b1.rsp_we_o;
    assign rdata  = sel ? b3.rsp_rdata_o : b1.rsp_rdata_o;

    mem_bank_pipe #(.AddrWidth(8), .DataSize(2), .RdLatency(1), .RspDepth(4)) u_dut1 (
        .clk_i(clk_i), .arst_ni(arst_ni), .bus(b1.slave));
    mem_bank_pipe #(.AddrWidth(8), .DataSize(2), .RdLatency(3), .RspDepth(4)) u_dut3 (
        .clk_i(clk_i), .arst_ni(arst_ni), .bus(b3.slave));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // Present one request (called just after a negedge), return after its accepting edge
    task automatic send(input logic we, input logic [7:0] addr, input logic [31:0] wd, input logic [3:0] st);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = st;
        while (!rdy && n < 50) begin @(negedge clk_i); n++; end
        if (n >= 50) timeout("send");
        @(negedge clk_i);
        req_valid = 1'b0;
    endtask

    // Wait for the head response, compare it, and pop it
    task automatic expect_rsp(input string name, input logic exp_we, input logic [31:0] exp_dat,
                              input logic [31:0] mask);
        int n = 0;
        rsp_ready = 1'b1;
        while (!vld && n < 50) begin @(negedge clk_i); n++; end
        if (n >= 50) timeout(name);
        else begin
            check({name, "_we"}, {31'b0, rsp_we}, {31'b0, exp_we});
            check({name, "_dat"}, rdata & mask, exp_dat);
        end
        @(negedge clk_i);
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_dat;
        logic [31:0] mask;
    } vec_t;

    vec_t        vecs [14];
    logic [7:0]  bp_addr [4];
    logic [31:0] bp_dat  [4];
    int          acc_cyc [16];
    int          nacc, nrsp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 8'h10, 32'hDDCCBBAA, 4'b1111, 32'h00000000, 32'hFFFFFFFF};
        vecs[1]  = '{1'b0, 8'h10, 32'h00000000, 4'b0000, 32'hDDCCBBAA, 32'hFFFFFFFF};
        vecs[2]  = '{1'b1, 8'h20, 32'hFFFFFFFF, 4'b1111, 32'h00000000, 32'hFFFFFFFF};
        vecs[3]  = '{1'b1, 8'h20, 32'h11223344, 4'b1010, 32'h00000000, 32'hFFFFFFFF};
        vecs[4]  = '{1'b1, 8'h20, 32'h55555555, 4'b0000, 32'h00000000, 32'hFFFFFFFF};
        vecs[5]  = '{1'b0, 8'h20, 32'h00000000, 4'b0000, 32'h11FF33FF, 32'hFFFFFFFF};
        vecs[6]  = '{1'b1, 8'hFE, 32'h44332211, 4'b1111, 32'h00000000, 32'hFFFFFFFF};
        vecs[7]  = '{1'b0, 8'hFE, 32'h00000000, 4'b0000, 32'h44332211, 32'hFFFFFFFF};
        vecs[8]  = '{1'b0, 8'h00, 32'h00000000, 4'b0000, 32'h00004433, 32'h0000FFFF};
        vecs[9]  = '{1'b0, 8'h11, 32'h00000000, 4'b0000, 32'h00DDCCBB, 32'h00FFFFFF};
        vecs[10] = '{1'b1, 8'h30, 32'h123456A5, 4'b0001, 32'h00000000, 32'hFFFFFFFF};
        vecs[11] = '{1'b0, 8'h30, 32'h00000000, 4'b0000, 32'h000000A5, 32'h000000FF};
        vecs[12] = '{1'b1, 8'h31, 32'h000000C3, 4'b0001, 32'h00000000, 32'hFFFFFFFF};
        vecs[13] = '{1'b0, 8'h30, 32'h00000000, 4'b0000, 32'h0000C3A5, 32'h0000FFFF};

        bp_addr[0] = 8'h10; bp_dat[0] = 32'hDDCCBBAA;
        bp_addr[1] = 8'h20; bp_dat[1] = 32'h11FF33FF;
        bp_addr[2] = 8'hFE; bp_dat[2] = 32'h44332211;
        bp_addr[3] = 8'h40; bp_dat[3] = 32'hCAFEF00D;

        arst_ni = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk_i);
        arst_ni = 1'b1;
        @(negedge clk_i);
        check("reset_rdy", {31'b0, rdy}, 32'd1);
        check("reset_vld", {31'b0, vld}, 32'd0);
        check("reset_we", {31'b0, rsp_we}, 32'd0);
        check("reset_rdata", rdata, 32'h0);

        // Table vectors, one outstanding request at a time
        for (int i = 0; i < 14; i++) begin
            send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            expect_rsp($sformatf("vec%0d", i), vecs[i].we, vecs[i].exp_dat, vecs[i].mask);
        end

        // RdLatency=1: valid the cycle right after accept, then held under stall
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
        @(negedge clk_i);
        req_valid = 1'b0;
        check("lat1_vld", {31'b0, vld}, 32'd1);
        check("lat1_dat", rdata, 32'hDDCCBBAA);
        @(negedge clk_i);
        check("hold_vld", {31'b0, vld}, 32'd1);
        check("hold_dat", rdata, 32'hDDCCBBAA);
        rsp_ready = 1'b1;
        @(negedge clk_i);
        check("lat1_empty", {31'b0, vld}, 32'd0);

        // Back-to-back write then read of the same word
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h40; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
        @(negedge clk_i);
        check("b2b_wvld", {31'b0, vld}, 32'd1);
        check("b2b_wwe", {31'b0, rsp_we}, 32'd1);
        req_we = 1'b0;
        @(negedge clk_i);
        req_valid = 1'b0;
        check("b2b_rvld", {31'b0, vld}, 32'd1);
        check("b2b_rwe", {31'b0, rsp_we}, 32'd0);
        check("b2b_rdat", rdata, 32'hCAFEF00D);
        @(negedge clk_i);
        check("b2b_empty", {31'b0, vld}, 32'd0);

        // Backpressure: continuous requests with responses stalled
        rsp_ready = 1'b0; nacc = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = bp_addr[0];
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (rdy) nacc++;
            @(negedge clk_i);
            if (nacc < 4) req_addr = bp_addr[nacc];
        end
        req_valid = 1'b0;
        check("bp_accepts", nacc, 32'd4);
        check("bp_full_rdy", {31'b0, rdy}, 32'd0);
        check("bp_stall_vld", {31'b0, vld}, 32'd1);
        check("bp_stall_dat", rdata, bp_dat[0]);
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_vld%0d", k), {31'b0, vld}, 32'd1);
            check($sformatf("bp_dat%0d", k), rdata, bp_dat[k]);
            if (k == 0) check("bp_rdy_before_pop", {31'b0, rdy}, 32'd0);
            if (k == 1) check("bp_rdy_after_pop", {31'b0, rdy}, 32'd1);
            @(negedge clk_i);
        end
        check("bp_drained", {31'b0, vld}, 32'd0);

        // Reset with three responses buffered
        rsp_ready = 1'b0;
        send(1'b0, 8'h10, 32'h0, 4'h0);
        send(1'b0, 8'h20, 32'h0, 4'h0);
        send(1'b0, 8'h30, 32'h0, 4'h0);
        check("rst_pre_vld", {31'b0, vld}, 32'd1);
        #2 arst_ni = 1'b0;
        #1;
        check("rst_async_vld", {31'b0, vld}, 32'd0);
        check("rst_async_we", {31'b0, rsp_we}, 32'd0);
        check("rst_async_rdata", rdata, 32'h0);
        @(negedge clk_i);
        arst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_rel_rdy", {31'b0, rdy}, 32'd1);
        check("rst_rel_vld", {31'b0, vld}, 32'd0);
        send(1'b0, 8'h10, 32'h0, 4'h0);
        expect_rsp("rst_mem10", 1'b0, 32'hDDCCBBAA, 32'hFFFFFFFF);
        send(1'b0, 8'h20, 32'h0, 4'h0);
        expect_rsp("rst_mem20", 1'b0, 32'h11FF33FF, 32'hFFFFFFFF);

        // RdLatency=3 bank: prefill a ramp, then stream 16 back-to-back reads
        sel = 1'b1;
        @(negedge clk_i);
        check("l3_reset_rdy", {31'b0, rdy}, 32'd1);
        check("l3_reset_vld", {31'b0, vld}, 32'd0);
        for (int j = 0; j < 16; j++) begin
            send(1'b1, 8'h80 + 8'(4 * j), 32'h10000000 + 32'(j), 4'hF);
            expect_rsp($sformatf("fill%0d", j), 1'b1, 32'h0, 32'hFFFFFFFF);
        end
        rsp_ready = 1'b1; nacc = 0; nrsp = 0;
        for (int j = 0; j < 16; j++) acc_cyc[j] = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (vld) begin
                if (nrsp < 16) begin
                    check($sformatf("stream_dat%0d", nrsp), rdata, 32'h10000000 + 32'(nrsp));
                    check($sformatf("stream_lat%0d", nrsp), cyc - acc_cyc[nrsp], 32'd3);
                end
                nrsp++;
            end
            if (nacc < 16) begin
                check($sformatf("stream_rdy%0d", nacc), {31'b0, rdy}, 32'd1);
                req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h80 + 8'(4 * nacc);
                if (rdy) begin
                    acc_cyc[nacc] = cyc;
                    nacc++;
                end
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk_i);
        end
        req_valid = 1'b0;
        check("stream_count", nrsp, 32'd16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
